multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle RISC-style controller: FSM sequencing fetch, decode,
// execute, memory and write-back, with optional memory wait states.
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_byte,
  output logic       alu_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [1:0] pc_src,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_R    = 4'd7,
    S_WB_I    = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_SLT = 3'b100;
  localparam logic [2:0] A_ADD = 3'b101;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_R   = 3'b111;

  state_t     st_q;
  state_t     st_d;
  logic [5:0] op_q;
  logic       rdy;

  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = st_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= S_FETCH;
      op_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE) op_q <= opcode;
    end
  end

  function automatic logic [2:0] i_alu_op(input logic [5:0] op);
    unique case (op)
      OP_SUBI: i_alu_op = A_SUB;
      OP_SLTI: i_alu_op = A_SLT;
      OP_ANDI: i_alu_op = A_AND;
      OP_ORI:  i_alu_op = A_OR;
      default: i_alu_op = A_ADD;
    endcase
  endfunction

  always_comb begin
    st_d       = st_q;
    alu_op     = A_ADD;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_byte   = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    unique case (st_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = rdy;
        pc_write = rdy;
        if (rdy) st_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_R:    st_d = S_EXEC_R;
          OP_ADDI, OP_SUBI, OP_SLTI,
          OP_ANDI, OP_ORI:
                   st_d = S_EXEC_I;
          OP_LW, OP_LB, OP_SW, OP_SB:
                   st_d = S_ADDR;
          OP_BEQ, OP_BNE:
                   st_d = S_BRANCH;
          OP_J:    st_d = S_JUMP;
          default: st_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_op = A_R;
        st_d   = S_WB_R;
      end
      S_WB_R: begin
        alu_op    = A_R;
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        st_d      = S_FETCH;
      end
      S_EXEC_I: begin
        alu_op  = i_alu_op(op_q);
        alu_src = 1'b1;
        st_d    = S_WB_I;
      end
      S_WB_I: begin
        alu_op    = i_alu_op(op_q);
        alu_src   = 1'b1;
        reg_write = 1'b1;
        st_d      = S_FETCH;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        st_d    = (op_q == OP_LW || op_q == OP_LB) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        mem_byte = (op_q == OP_LB);
        if (rdy) st_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        mem_byte   = (op_q == OP_LB);
        st_d       = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        mem_byte  = (op_q == OP_SB);
        if (rdy) st_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_op   = A_SUB;
        pc_src   = 2'b01;
        pc_write = ((op_q == OP_BEQ) & alu_zero) |
                   ((op_q == OP_BNE) & ~alu_zero);
        st_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        st_d     = S_FETCH;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   st_d = S_FETCH;
    endcase
    // Reset is async, so kill write strobes before the state register settles
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule
